// File: rtl/pc_pkg.sv
// Shared encodings and types for the program-counter unit.
// pc_sel codes 5..7 are reserved and fall back to increment.
package pc_pkg;

    localparam int PC_SEL_W = 3;

    typedef enum logic [PC_SEL_W-1:0] {
        PC_SEL_INC   = 3'd0,
        PC_SEL_BUS   = 3'd1,
        PC_SEL_ADDER = 3'd2,
        PC_SEL_RAS   = 3'd3,
        PC_SEL_VEC   = 3'd4
    } pc_sel_e;

    typedef struct packed {
        logic ovf;
        logic udf;
        logic align;
        logic sel;
    } err_flags_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/datapath-facing signal bundle of the program-counter unit.
// master = control FSM + datapath side, slave = pc_unit.
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic                ld_pc;
    logic [PC_SEL_W-1:0] pc_sel;
    logic [WIDTH-1:0]    bus;
    logic [WIDTH-1:0]    adder;
    logic                push;
    logic                clr_err;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_inc;
    logic [CW-1:0]       ras_count;
    logic                ras_empty;
    logic                ras_full;
    logic                ovf_err;
    logic                udf_err;
    logic                align_err;
    logic                sel_err;

    modport master (
        output ld_pc, pc_sel, bus, adder, push, clr_err,
        input  pc, pc_inc, ras_count, ras_empty, ras_full,
               ovf_err, udf_err, align_err, sel_err
    );

    modport slave (
        input  ld_pc, pc_sel, bus, adder, push, clr_err,
        output pc, pc_inc, ras_count, ras_empty, ras_full,
               ovf_err, udf_err, align_err, sel_err
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop, swap (push+pop), overwrite-oldest
// when full, with single-cycle overflow/underflow strobes.
module ras_stack #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4,
    localparam int CW = $clog2(RAS_DEPTH + 1),
    localparam int PW = $clog2(RAS_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [WIDTH-1:0] entries [RAS_DEPTH];

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(RAS_DEPTH));
    assign count    = count_reg;
    assign top_data = entries[ptr_reg - PW'(1)];

    // ptr_reg is the next free slot; when full it also addresses the oldest
    // entry, so a plain push naturally overwrites it.
    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_idx     = ptr_reg;
        ovf        = 1'b0;
        udf        = 1'b0;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = ptr_reg - PW'(1);
        end else if (push) begin
            wr_en      = 1'b1;
            ptr_next   = ptr_reg + PW'(1);
            udf        = pop;
            ovf        = !pop && full;
            count_next = full ? count_reg : count_reg + CW'(1);
        end else if (pop) begin
            if (empty) begin
                udf = 1'b1;
            end else begin
                ptr_next   = ptr_reg - PW'(1);
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (wr_en && wr_idx == PW'(gi)) begin
                entry_reg <= push_data;
            end
        end
        assign entries[gi] = entry_reg;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: source mux, alignment enforcement, PC register,
// return-address stack and sticky error flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               INC_STEP  = 2,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] VEC_ADDR  = WIDTH'(16'h0200),
    parameter int               RAS_DEPTH = 4,
    parameter int               ALIGN     = 1
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.slave   pif
);

    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_reg, pc_next, pc_inc, target, ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_empty, ras_full, ras_ovf, ras_udf;
    logic             ras_push, ras_pop, sel_ev, align_ev;
    err_flags_t       err_reg, err_next, err_ev;

    assign pc_inc   = pc_reg + WIDTH'(INC_STEP);
    assign ras_push = pif.ld_pc && pif.push;
    assign ras_pop  = pif.ld_pc && (pif.pc_sel == PC_SEL_RAS);

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .ovf       (ras_ovf),
        .udf       (ras_udf)
    );

    always_comb begin
        target = pc_inc;
        sel_ev = 1'b0;
        case (pif.pc_sel)
            PC_SEL_INC:   target = pc_inc;
            PC_SEL_BUS:   target = pif.bus;
            PC_SEL_ADDER: target = pif.adder;
            PC_SEL_RAS:   target = ras_empty ? VEC_ADDR : ras_top;
            PC_SEL_VEC:   target = VEC_ADDR;
            default: begin
                target = pc_inc;
                sel_ev = 1'b1;
            end
        endcase

        // Every source goes through the alignment check, RAS and vector included.
        pc_next  = target;
        align_ev = 1'b0;
        if (ALIGN != 0 && target[0]) begin
            pc_next[0] = 1'b0;
            align_ev   = 1'b1;
        end

        err_ev.ovf   = ras_ovf;
        err_ev.udf   = ras_udf;
        err_ev.align = pif.ld_pc && align_ev;
        err_ev.sel   = pif.ld_pc && sel_ev;
        // A fresh error in the clearing cycle survives the clear.
        err_next = err_flags_t'((pif.clr_err ? '0 : err_reg) | err_ev);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= RESET_PC;
            err_reg <= '0;
        end else begin
            if (pif.ld_pc) begin
                pc_reg <= pc_next;
            end
            err_reg <= err_next;
        end
    end

    assign pif.pc        = pc_reg;
    assign pif.pc_inc    = pc_inc;
    assign pif.ras_count = ras_count;
    assign pif.ras_empty = ras_empty;
    assign pif.ras_full  = ras_full;
    assign pif.ovf_err   = err_reg.ovf;
    assign pif.udf_err   = err_reg.udf;
    assign pif.align_err = err_reg.align;
    assign pif.sel_err   = err_reg.sel;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each step queues its expected PC/count/flags,
// the queue head is compared one cycle later.
module tb_pc_unit;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(16), .RAS_DEPTH(4)) pif ();

    pc_unit #(
        .WIDTH     (16),
        .INC_STEP  (2),
        .RESET_PC  (16'h0000),
        .VEC_ADDR  (16'h0200),
        .RAS_DEPTH (4),
        .ALIGN     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic [3:0]  err;   // {ovf, udf, align, sel}
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [15:0] epc,
                                input logic [2:0] ecnt, input logic [3:0] eerr);
        exp_t e;
        e.tag = tag; e.pc = epc; e.cnt = ecnt; e.err = eerr;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [15:0] epc_inc;
        e       = sb.pop_front();
        epc_inc = e.pc + 16'd2;
        chk({e.tag, ".pc"},     32'(pif.pc),        32'(e.pc));
        chk({e.tag, ".pc_inc"}, 32'(pif.pc_inc),    32'(epc_inc));
        chk({e.tag, ".count"},  32'(pif.ras_count), 32'(e.cnt));
        chk({e.tag, ".empty"},  32'(pif.ras_empty), 32'(e.cnt == 3'd0));
        chk({e.tag, ".full"},   32'(pif.ras_full),  32'(e.cnt == 3'd4));
        chk({e.tag, ".errs"},
            32'({pif.ovf_err, pif.udf_err, pif.align_err, pif.sel_err}), 32'(e.err));
        $display("step %-12s pc=%h cnt=%0d errs=%b", e.tag, pif.pc, pif.ras_count,
                 {pif.ovf_err, pif.udf_err, pif.align_err, pif.sel_err});
    endtask

    task automatic apply(input string tag, input logic ld, input logic [2:0] sel,
                         input logic [15:0] b, input logic [15:0] a,
                         input logic ps, input logic cl,
                         input logic [15:0] epc, input logic [2:0] ecnt,
                         input logic [3:0] eerr);
        @(negedge clk);
        pif.ld_pc   = ld;
        pif.pc_sel  = sel;
        pif.bus     = b;
        pif.adder   = a;
        pif.push    = ps;
        pif.clr_err = cl;
        expect_state(tag, epc, ecnt, eerr);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        pif.ld_pc   = 1'b0;
        pif.pc_sel  = 3'd0;
        pif.bus     = 16'h0;
        pif.adder   = 16'h0;
        pif.push    = 1'b0;
        pif.clr_err = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset", 16'h0000, 3'd0, 4'b0000);
        check_out();
        @(negedge clk);
        rst = 1'b0;

        // Increment sequence, then asynchronous reset mid-run
        apply("inc1", 1, 3'd0, 16'h0, 16'h0, 0, 0, 16'h0002, 3'd0, 4'b0000);
        apply("inc2", 1, 3'd0, 16'h0, 16'h0, 0, 0, 16'h0004, 3'd0, 4'b0000);
        apply("inc3", 1, 3'd0, 16'h0, 16'h0, 0, 0, 16'h0006, 3'd0, 4'b0000);
        @(negedge clk);
        pif.ld_pc = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_state("async_rst", 16'h0000, 3'd0, 4'b0000);
        check_out();
        #1 rst = 1'b0;

        // Alignment fault on odd bus target, then clear
        apply("bus_odd", 1, 3'd1, 16'h0069, 16'h0, 0, 0, 16'h0068, 3'd0, 4'b0010);
        apply("clr1",    0, 3'd0, 16'h0,    16'h0, 0, 1, 16'h0068, 3'd0, 4'b0000);

        // JSR through adder, RET through RAS
        apply("bus100", 1, 3'd1, 16'h0100, 16'h0,    0, 0, 16'h0100, 3'd0, 4'b0000);
        apply("jsr",    1, 3'd2, 16'h0,    16'h0400, 1, 0, 16'h0400, 3'd1, 4'b0000);
        apply("ret",    1, 3'd3, 16'h0,    16'h0,    0, 0, 16'h0102, 3'd0, 4'b0000);

        // Five pushes at depth 4: oldest overwritten, ovf sticky
        apply("push1", 1, 3'd1, 16'h0010, 16'h0, 1, 0, 16'h0010, 3'd1, 4'b0000);
        apply("push2", 1, 3'd1, 16'h0020, 16'h0, 1, 0, 16'h0020, 3'd2, 4'b0000);
        apply("push3", 1, 3'd1, 16'h0030, 16'h0, 1, 0, 16'h0030, 3'd3, 4'b0000);
        apply("push4", 1, 3'd1, 16'h0040, 16'h0, 1, 0, 16'h0040, 3'd4, 4'b0000);
        apply("push5", 1, 3'd1, 16'h0050, 16'h0, 1, 0, 16'h0050, 3'd4, 4'b1000);
        apply("pop1",  1, 3'd3, 16'h0,    16'h0, 0, 0, 16'h0042, 3'd3, 4'b1000);
        apply("pop2",  1, 3'd3, 16'h0,    16'h0, 0, 0, 16'h0032, 3'd2, 4'b1000);
        apply("pop3",  1, 3'd3, 16'h0,    16'h0, 0, 0, 16'h0022, 3'd1, 4'b1000);
        apply("pop4",  1, 3'd3, 16'h0,    16'h0, 0, 0, 16'h0012, 3'd0, 4'b1000);
        apply("clr2",  0, 3'd0, 16'h0,    16'h0, 0, 1, 16'h0012, 3'd0, 4'b0000);

        // Pop on empty goes to the vector; ld_pc=0 holds everything
        apply("pop_empty", 1, 3'd3, 16'h0, 16'h0, 0, 0, 16'h0200, 3'd0, 4'b0100);
        apply("hold",      0, 3'd0, 16'h0, 16'h0, 1, 0, 16'h0200, 3'd0, 4'b0100);
        apply("clr3",      0, 3'd0, 16'h0, 16'h0, 0, 1, 16'h0200, 3'd0, 4'b0000);

        // Increment wrap, reserved select, swap
        apply("bus_fffe", 1, 3'd1, 16'hFFFE, 16'h0, 0, 0, 16'hFFFE, 3'd0, 4'b0000);
        apply("inc_wrap", 1, 3'd0, 16'h0,    16'h0, 0, 0, 16'h0000, 3'd0, 4'b0000);
        apply("sel7",     1, 3'd7, 16'h0,    16'h0, 0, 0, 16'h0002, 3'd0, 4'b0001);
        apply("clr4",     0, 3'd0, 16'h0,    16'h0, 0, 1, 16'h0002, 3'd0, 4'b0000);
        apply("jsr300",   1, 3'd1, 16'h0300, 16'h0, 1, 0, 16'h0300, 3'd1, 4'b0000);
        apply("swap",     1, 3'd3, 16'h0,    16'h0, 1, 0, 16'h0004, 3'd1, 4'b0000);
        apply("ret_swap", 1, 3'd3, 16'h0,    16'h0, 0, 0, 16'h0302, 3'd0, 4'b0000);
        apply("swap_mt",  1, 3'd3, 16'h0,    16'h0, 1, 0, 16'h0200, 3'd1, 4'b0100);
        apply("ret_mt",   1, 3'd3, 16'h0,    16'h0, 0, 0, 16'h0304, 3'd0, 4'b0100);
        // Clear and a new error in the same cycle: the new one survives
        apply("clr_new",  1, 3'd5, 16'h0,    16'h0, 0, 1, 16'h0306, 3'd0, 4'b0001);

        @(negedge clk);
        pif.ld_pc   = 1'b0;
        pif.clr_err = 1'b0;
        pif.push    = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
